// File: rtl/dec2hex_pkg.sv
// dec2hex_pkg: shared types and constants for the decimal-ASCII-to-binary converter.
//   state_t    : converter FSM states (IDLE, ACCUM, DONE)
//   ASCII_ZERO : character code of '0'
//   ASCII_NINE : character code of '9'
//   MAX_DIGITS : digits accepted per conversion
//   MAX_VALUE  : saturation value of the 17-bit accumulator
package dec2hex_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [7:0]  ASCII_ZERO = 8'h30;
   localparam logic [7:0]  ASCII_NINE = 8'h39;
   localparam int          MAX_DIGITS = 5;
   localparam logic [16:0] MAX_VALUE  = 17'h0FFFF;

   function automatic logic is_ascii_digit(input logic [7:0] c);
      return (c >= ASCII_ZERO) && (c <= ASCII_NINE);
   endfunction

endpackage

// File: rtl/dec2hex_mac10.sv
// mac10: combinational acc*10+digit with overflow detection and saturation.
//   acc    in  17 : running accumulator
//   digit  in   4 : decimal digit 0..9
//   result out 17 : acc*10+digit, or MAX_VALUE on overflow
//   ovf    out  1 : product exceeded 16 bits
module mac10
   import dec2hex_pkg::*;
(
   input  logic [16:0] acc,
   input  logic [3:0]  digit,
   output logic [16:0] result,
   output logic        ovf
);

   logic [19:0] acc_w;
   logic [19:0] prod;

   // acc*10 as (acc<<3)+(acc<<1), kept at 20 bits so a saturated 17'h0FFFF
   // times ten still fits and is reported as overflow again
   always_comb begin
      acc_w  = {3'b000, acc};
      prod   = (acc_w << 3) + (acc_w << 1) + {16'h0000, digit};
      ovf    = |prod[19:16];
      result = ovf ? MAX_VALUE : prod[16:0];
   end

endmodule

// File: rtl/dec2hex.sv
// dec2hex: converts a stream of up to 5 ASCII decimal digits into a 16-bit value.
//   clk        in   1 : clock, posedge
//   rst        in   1 : asynchronous active-high reset
//   start      in   1 : begin conversion, sampled in IDLE only
//   ascii_data in   8 : digit character, sampled with valid in ACCUM
//   valid      in   1 : one digit per high cycle
//   hex_data   out 16 : converted value, held until the next done
//   done       out  1 : one-cycle completion pulse
//   err        out  1 : non-digit, overflow or timeout seen, held with hex_data
//   ready      out  1 : idle and able to accept start
module dec2hex
   import dec2hex_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  ascii_data,
   input  logic        valid,
   output logic [15:0] hex_data,
   output logic        done,
   output logic        err,
   output logic        ready
);

   localparam logic [7:0] TIMEOUT  = 8'(TIMEOUT_CYCLES);
   localparam logic [2:0] LAST_CNT = 3'(MAX_DIGITS - 1);

   state_t      state;
   logic [16:0] acc;
   logic [2:0]  cnt;
   logic [7:0]  timer;
   logic        serr;

   logic        is_digit;
   logic [3:0]  digit;
   logic [16:0] mac_res;
   logic        mac_ovf;
   logic [16:0] acc_nxt;
   logic        serr_nxt;
   logic [7:0]  timer_nxt;

   mac10 u_mac10 (
      .acc    (acc),
      .digit  (digit),
      .result (mac_res),
      .ovf    (mac_ovf)
   );

   // '0'..'9' are 8'h30..8'h39, so the low nibble is the digit value
   always_comb begin
      is_digit  = is_ascii_digit(ascii_data);
      digit     = ascii_data[3:0];
      acc_nxt   = is_digit ? mac_res : acc;
      serr_nxt  = serr | ~is_digit | mac_ovf;
      timer_nxt = timer + 8'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         acc      <= '0;
         cnt      <= '0;
         timer    <= '0;
         serr     <= 1'b0;
         hex_data <= '0;
         done     <= 1'b0;
         err      <= 1'b0;
         ready    <= 1'b1;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state <= ACCUM;
                  acc   <= '0;
                  cnt   <= '0;
                  timer <= '0;
                  serr  <= 1'b0;
                  ready <= 1'b0;
               end
            end
            ACCUM: begin
               if (valid) begin
                  acc  <= acc_nxt;
                  serr <= serr_nxt;
                  cnt  <= cnt + 3'd1;
                  // the final digit goes straight to the output registers
                  if (cnt == LAST_CNT) begin
                     state    <= DONE;
                     hex_data <= acc_nxt[15:0];
                     err      <= serr_nxt;
                     done     <= 1'b1;
                  end
               end else if (cnt != 3'd0) begin
                  state    <= DONE;
                  hex_data <= acc[15:0];
                  err      <= serr;
                  done     <= 1'b1;
               end else begin
                  timer <= timer_nxt;
                  if (timer_nxt == TIMEOUT) begin
                     state    <= DONE;
                     acc      <= '0;
                     serr     <= 1'b1;
                     hex_data <= '0;
                     err      <= 1'b1;
                     done     <= 1'b1;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               ready <= 1'b1;
            end
            default: begin
               state <= IDLE;
               ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: doc/dec2hex.md
# dec2hex

Decimal-ASCII-to-binary converter: the receive-side counterpart of the 16-bit binary-to-decimal-ASCII stream producer.
- Consumes a stream of ASCII decimal digits (`'0'`–`'9'`, most-significant digit first, up to 5 digits, leading zeros allowed) framed by a `valid` strobe.
- Returns the 16-bit unsigned binary value with a one-cycle `done` pulse and an error flag.
- Sits on the console/command path, downstream of any stream that emits one digit per `valid` cycle.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 64: maximum idle cycles in ACCUM before the first digit; range 1..255.

Ports:
- `clk` in 1: single clock; all logic on posedge.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: begin a conversion; sampled only in IDLE.
- `ascii_data` in 8: digit character; sampled when `valid`=1 in ACCUM.
- `valid` in 1: digit strobe; one digit per high cycle.
- `hex_data` out 16: converted value; held until next `done`.
- `done` out 1: one-cycle pulse; `hex_data`/`err` valid in that cycle.
- `err` out 1: non-digit, overflow or timeout seen in this conversion; held with `hex_data`.
- `ready` out 1: high in IDLE, ready for `start`.

## Operation
- Reset values: `hex_data`=0, `done`=0, `err`=0, `ready`=1, state IDLE, acc=0, digit count=0, timer=0.
- States:
  - IDLE: `ready`=1. `start` → ACCUM; clear acc, count, timer, sticky error; `ready`<=0. `valid` in IDLE is ignored, including in the same cycle as `start`.
  - ACCUM, `valid`=1:
    - digit d = `ascii_data`−8'h30 when `ascii_data` is in 8'h30..8'h39: acc <= acc*10+d.
    - non-digit: acc unchanged, sticky error set.
    - Either case: count++. At the 5th accepted `valid` → DONE.
  - ACCUM, `valid`=0:
    - count>0 → DONE (end of number).
    - count==0: timer++; timer reaching `TIMEOUT_CYCLES` → DONE with sticky error set and acc=0.
  - DONE: `done`=1 for exactly this cycle → IDLE, `ready`<=1.
- Arithmetic: acc is 17 bits wide; the product acc*10+d is computed at 20 bits. A result >65535 sets the sticky error and saturates acc to 17'h0FFFF; further digits keep it saturated.
- `hex_data` <= acc[15:0] and `err` <= sticky error, on the edge that enters DONE.
- `start` outside IDLE is ignored. `valid` in DONE is dropped without an error; the transmitter must not exceed 5 digits.
- Reset mid-conversion: all state returns to reset values immediately; no `done` is produced for the aborted conversion.

## Timing
- `start` sampled at edge 0 → ACCUM from cycle 1; digits accepted back-to-back, one per cycle.
- Number of n<5 digits: `done` is high in the cycle after the edge that samples `valid`=0.
- 5 digits: `done` is high in the cycle immediately after the edge that samples the 5th digit.
- Minimum conversion: 5 digits from cycle 1 → `done` in cycle 6, `ready` in cycle 7.
- Timeout: `done` in the cycle after the `TIMEOUT_CYCLES`-th idle sample.
- All outputs are registered; no combinational input→output paths.

## Structure
- Package `dec2hex_pkg`:
  - state enum (IDLE, ACCUM, DONE);
  - `ASCII_ZERO`=8'h30, `ASCII_NINE`=8'h39;
  - `MAX_DIGITS`=5, `MAX_VALUE`=17'h0FFFF.
- One sub-module `mac10`: combinational acc*10+d using shift-add ((acc<<3)+(acc<<1)+d), with an overflow output and saturation. Kept separate for unit testing.
- FSM, counters and output registers live in the top module.

## Test plan
- start; "00123" back-to-back on cycles 1–5 → `done` cycle 6, `hex_data`=16'h007B, `err`=0, `ready`=1 cycle 7.
- "65535" → 16'hFFFF, `err`=0; "65536" → 16'hFFFF, `err`=1; "99999" → 16'hFFFF, `err`=1.
- "42" then `valid` low → `hex_data`=16'h002A, `err`=0, `done` in the cycle after low is sampled; a lone "0" → 16'h0000, `err`=0.
- "1A3" then `valid` low → `hex_data`=16'h000D, `err`=1.
- start with no `valid` for 64 cycles → `done`, `hex_data`=0, `err`=1. `start` pulses during ACCUM and a `valid` coincident with `start` are ignored.
- `rst` asserted after 3 digits → all outputs at reset values with no `done`. A following "00007" conversion → 16'h0007; loopback from the binary-to-decimal producer over 0, 1, 9999, 65535 → values match.
